lvds_ddr_word_aligner: RTL and testbench

Parametrised successor to the fixed 8-lane DDR ADC capture logic. It takes per-lane rising/falling-edge bits from the IDDR stage and assembles 2*N_LANES-bit samples. It adds training-pattern word alignment through a half-cycle phase slip, lock detection and an output-format option. It sits between the IDDR primitives in the LVDS capture wrapper and the sample FIFO.

---
 rtl/lvds_ddr_word_aligner_pkg.sv | 20 ++
 rtl/lvds_ddr_word_aligner_if.sv | 27 ++
 rtl/lvds_ddr_word_aligner_assembler.sv | 49 ++++
 rtl/lvds_ddr_word_aligner.sv | 98 +++++++++
 tb/tb_lvds_ddr_word_aligner.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/lvds_ddr_word_aligner_pkg.sv
// Shared types and helpers for the LVDS DDR capture path.
// The FSM state type, the default training word and the per-lane bit-ordering helper.
package lvds_capture_pkg;

    typedef enum logic [2:0] {IDLE, SETTLE, SEARCH, LOCKED, FAILED} align_state_t;

    localparam logic [15:0] TRAIN_PATTERN_DEFAULT = 16'hA53C;

    // Returns {odd, even} bits of one lane's two-bit slot.
    // Phase 1 pairs the current rising bit with the previous falling bit.
    function automatic logic [1:0] word_assemble(
        input logic r,
        input logic f,
        input logic f_prev,
        input logic phase
    );
        return phase ? {f_prev, r} : {r, f};
    endfunction

endpackage

// File: rtl/lvds_ddr_word_aligner_if.sv
// Capture-side bundle between the IDDR wrapper (master) and the word aligner (slave).
// Free-running streaming signals, so there is no backpressure.
interface lvds_ddr_word_aligner_if
    import lvds_capture_pkg::*;
#(
    parameter int N_LANES = 8
);
    logic [N_LANES-1:0]   rise_bits;
    logic [N_LANES-1:0]   fall_bits;
    logic                 align_req;
    logic                 fmt_twos;
    logic [2*N_LANES-1:0] adc_data;
    logic                 adc_valid;
    logic                 locked;
    logic                 align_fail;
    logic                 phase;

    modport master (
        output rise_bits, fall_bits, align_req, fmt_twos,
        input  adc_data, adc_valid, locked, align_fail, phase
    );

    modport slave (
        input  rise_bits, fall_bits, align_req, fmt_twos,
        output adc_data, adc_valid, locked, align_fail, phase
    );
endinterface

// File: rtl/lvds_ddr_word_aligner_assembler.sv
// Two-stage DDR word assembly: input register, phase mux and output format register.
// Latency is 2 clk from the input bits to adc_data_o. It has no backpressure and updates every cycle.
module lvds_ddr_word_assembler
    import lvds_capture_pkg::*;
#(
    parameter int N_LANES = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_LANES-1:0]   rise_bits_i,
    input  logic [N_LANES-1:0]   fall_bits_i,
    input  logic                 phase_i,
    input  logic                 fmt_twos_i,
    output logic [2*N_LANES-1:0] word_o,
    output logic [2*N_LANES-1:0] adc_data_o
);
    localparam int W = 2 * N_LANES;

    logic [N_LANES-1:0] r_q, f_q, f_q2;
    logic [W-1:0]       word;
    logic [W-1:0]       adc_data_d, adc_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q        <= '0;
            f_q        <= '0;
            f_q2       <= '0;
            adc_data_q <= '0;
        end else begin
            r_q        <= rise_bits_i;
            f_q        <= fall_bits_i;
            f_q2       <= f_q;
            adc_data_q <= adc_data_d;
        end
    end

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        assign word[2*i +: 2] = word_assemble(r_q[i], f_q[i], f_q2[i], phase_i);
    end

    // The format option applies only to the output, so the aligner matches the raw word.
    always_comb begin
        adc_data_d        = word;
        adc_data_d[W-1]   = word[W-1] ^ fmt_twos_i;
    end

    assign word_o     = word;
    assign adc_data_o = adc_data_q;
endmodule

// File: rtl/lvds_ddr_word_aligner.sv
// DDR ADC word aligner. It assembles samples, slips phase against a training word and then reports lock or failure.
// Data latency is 2 clk. The block is free-running with no backpressure, and align_req restarts alignment from any state.
module lvds_ddr_word_aligner
    import lvds_capture_pkg::*;
#(
    parameter int                   N_LANES       = 8,
    parameter logic [2*N_LANES-1:0] TRAIN_PATTERN = (2*N_LANES)'(TRAIN_PATTERN_DEFAULT),
    parameter int                   MATCH_COUNT   = 16,
    parameter int                   SLIP_WAIT     = 8,
    parameter int                   MAX_SLIPS     = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    lvds_ddr_word_aligner_if.slave bus
);
    localparam int W  = 2 * N_LANES;
    localparam int MW = $clog2(MATCH_COUNT) + 1;
    localparam int SW = $clog2(SLIP_WAIT) + 1;
    localparam int LW = $clog2(MAX_SLIPS) + 1;

    localparam logic [MW-1:0] MATCH_FULL  = MW'(MATCH_COUNT);
    localparam logic [MW-1:0] MATCH_LAST  = MW'(MATCH_COUNT - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SLIP_WAIT - 1);
    localparam logic [LW-1:0] SLIP_MAX    = LW'(MAX_SLIPS);

    align_state_t  state_q;
    logic [MW-1:0] match_q;
    logic [SW-1:0] settle_q;
    logic [LW-1:0] slip_q;
    logic          phase_q, locked_q, valid_q, fail_q;
    logic [W-1:0]  word;

    lvds_ddr_word_assembler #(.N_LANES(N_LANES)) u_asm (
        .clk         (clk),
        .rst_n       (rst_n),
        .rise_bits_i (bus.rise_bits),
        .fall_bits_i (bus.fall_bits),
        .phase_i     (phase_q),
        .fmt_twos_i  (bus.fmt_twos),
        .word_o      (word),
        .adc_data_o  (bus.adc_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            match_q  <= '0;
            settle_q <= '0;
            slip_q   <= '0;
            phase_q  <= 1'b0;
            locked_q <= 1'b0;
            valid_q  <= 1'b0;
            fail_q   <= 1'b0;
        end else if (bus.align_req) begin
            // A restart takes priority over everything, including a lock on this very edge.
            state_q  <= SETTLE;
            match_q  <= '0;
            settle_q <= '0;
            slip_q   <= '0;
            phase_q  <= 1'b0;
            locked_q <= 1'b0;
            valid_q  <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            case (state_q)
                SETTLE: begin
                    if (settle_q == SETTLE_LAST) state_q  <= SEARCH;
                    else                         settle_q <= settle_q + 1'b1;
                end
                SEARCH: begin
                    if (word == TRAIN_PATTERN) begin
                        if (match_q != MATCH_FULL) match_q <= match_q + 1'b1;
                        if (match_q == MATCH_LAST) begin
                            state_q  <= LOCKED;
                            locked_q <= 1'b1;
                            valid_q  <= 1'b1;
                        end
                    end else if (slip_q < SLIP_MAX) begin
                        state_q  <= SETTLE;
                        phase_q  <= ~phase_q;
                        slip_q   <= slip_q + 1'b1;
                        match_q  <= '0;
                        settle_q <= '0;
                    end else begin
                        state_q <= FAILED;
                        fail_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.adc_valid  = valid_q;
    assign bus.locked     = locked_q;
    assign bus.align_fail = fail_q;
    assign bus.phase      = phase_q;
endmodule

// File: tb/tb_lvds_ddr_word_aligner.sv
// Scoreboard bench for the DDR word aligner: directed stimulus pushes expectations, and a monitor checks them on their due cycle.
module tb_lvds_ddr_word_aligner;
    import lvds_capture_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lvds_ddr_word_aligner_if #(.N_LANES(8)) bus ();

    lvds_ddr_word_aligner #(
        .N_LANES       (8),
        .TRAIN_PATTERN (16'hA53C),
        .MATCH_COUNT   (16),
        .SLIP_WAIT     (8),
        .MAX_SLIPS     (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct packed {
        int            due;
        bit            async_chk;
        bit            chk_data;
        logic [15:0]   data;
        bit            chk_stat;
        logic [3:0]    stat;   // {adc_valid, locked, align_fail, phase}
        logic [127:0]  name;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input logic [127:0] nm, input logic [15:0] act, input logic [15:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %0s: got %h, expected %h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    task automatic check_item(input exp_t e);
        if (e.chk_data) cmp(e.name, bus.adc_data, e.data);
        if (e.chk_stat) cmp(e.name, {12'h0, bus.adc_valid, bus.locked, bus.align_fail, bus.phase},
                            {12'h0, e.stat});
    endtask

    task automatic push(input logic [127:0] nm, input int dly, input bit as, input bit cd,
                        input logic [15:0] d, input bit cs, input logic [3:0] st);
        exp_t e;
        e.due = cyc + dly; e.async_chk = as; e.chk_data = cd; e.data = d;
        e.chk_stat = cs; e.stat = st; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic expect_data(input logic [127:0] nm, input int dly, input logic [15:0] d);
        push(nm, dly, 1'b0, 1'b1, d, 1'b0, 4'h0);
    endtask

    task automatic expect_stat(input logic [127:0] nm, input int dly, input logic [3:0] st);
        push(nm, dly, 1'b0, 1'b0, 16'h0, 1'b1, st);
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (!sb[i].async_chk && sb[i].due <= cyc) begin
                check_item(sb[i]);
                sb.delete(i);
            end
        end
    end

    always @(negedge rst_n) begin
        #1;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].async_chk) begin
                check_item(sb[i]);
                sb.delete(i);
            end
        end
    end

    function automatic logic [7:0] odd8(input logic [15:0] w);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = w[2*i+1];
        return v;
    endfunction

    function automatic logic [7:0] even8(input logic [15:0] w);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = w[2*i];
        return v;
    endfunction

    task automatic drive(input logic [7:0] r, input logic [7:0] f, input logic req, input logic fmt);
        @(negedge clk);
        bus.rise_bits = r;
        bus.fall_bits = f;
        bus.align_req = req;
        bus.fmt_twos  = fmt;
    endtask

    // Phase-0 encoding of a whole word: rising bits are odd, falling bits are even.
    task automatic drive_w(input logic [15:0] w, input logic req, input logic fmt);
        drive(odd8(w), even8(w), req, fmt);
    endtask

    initial begin
        bus.rise_bits = '0;
        bus.fall_bits = '0;
        bus.align_req = 1'b0;
        bus.fmt_twos  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        expect_stat("reset_stat", 1, 4'b0000);
        expect_data("reset_data", 1, 16'h0000);

        // Phase-0 lock: 1 request edge + 8 settle + 16 matches.
        drive_w(16'hA53C, 1'b1, 1'b0);
        expect_stat("p0_req", 1, 4'b0000);
        expect_stat("p0_prelock", 24, 4'b0000);
        expect_stat("p0_lock", 25, 4'b1100);
        repeat (25) drive_w(16'hA53C, 1'b0, 1'b0);
        drive_w(16'h1234, 1'b0, 1'b0);
        expect_data("p0_1234", 2, 16'h1234);
        expect_stat("p0_valid", 2, 4'b1100);
        repeat (2) drive_w(16'hA53C, 1'b0, 1'b0);

        // Output format while locked.
        drive_w(16'h8001, 1'b0, 1'b1);
        drive_w(16'h8001, 1'b0, 1'b1);
        expect_data("fmt_twos", 2, 16'h0001);
        drive_w(16'h8001, 1'b0, 1'b1);
        drive_w(16'h8001, 1'b0, 1'b0);
        drive_w(16'h8001, 1'b0, 1'b0);
        expect_data("fmt_offset", 2, 16'h8001);
        expect_stat("fmt_lock", 2, 4'b1100);
        repeat (3) drive_w(16'hA53C, 1'b0, 1'b0);

        // Restart from LOCKED, then a restart landing on the 16th match.
        drive_w(16'hA53C, 1'b1, 1'b0);
        expect_stat("rst_from_lock", 1, 4'b0000);
        expect_stat("relock", 25, 4'b1100);
        repeat (25) drive_w(16'hA53C, 1'b0, 1'b0);
        drive_w(16'hA53C, 1'b1, 1'b0);
        repeat (23) drive_w(16'hA53C, 1'b0, 1'b0);
        drive_w(16'hA53C, 1'b1, 1'b0);
        expect_stat("coinc_nolock", 1, 4'b0000);
        expect_stat("coinc_prelock", 24, 4'b0000);
        expect_stat("coinc_relock", 25, 4'b1100);
        repeat (25) drive_w(16'hA53C, 1'b0, 1'b0);

        // Phase-1 lock: even bits ride on rise, odd bits on the previous fall.
        drive(8'h36, 8'hC6, 1'b1, 1'b0);
        expect_stat("p1_before_slip", 9, 4'b0000);
        expect_stat("p1_slip", 10, 4'b0001);
        expect_stat("p1_prelock", 33, 4'b0001);
        expect_stat("p1_lock", 34, 4'b1101);
        repeat (34) drive(8'h36, 8'hC6, 1'b0, 1'b0);
        drive(8'h00, 8'h14, 1'b0, 1'b0);
        drive(8'h46, 8'hFF, 1'b0, 1'b0);
        expect_data("p1_mix", 2, 16'h1234);
        drive(8'h00, 8'h00, 1'b0, 1'b0);
        expect_data("p1_fprev", 2, 16'hAAAA);
        drive(8'h00, 8'h00, 1'b0, 1'b0);

        // Failure on a constant zero stream after four slips.
        drive(8'h00, 8'h00, 1'b1, 1'b0);
        expect_stat("fail_mid", 11, 4'b0001);
        expect_stat("fail_pre", 45, 4'b0000);
        expect_stat("fail_set", 46, 4'b0010);
        expect_data("fail_data", 46, 16'h0000);
        repeat (50) drive(8'h00, 8'h00, 1'b0, 1'b0);
        expect_stat("fail_hold", 1, 4'b0010);
        drive(8'h00, 8'h00, 1'b1, 1'b0);
        expect_stat("fail_clear", 1, 4'b0000);
        drive(8'h00, 8'h00, 1'b0, 1'b0);

        // Asynchronous reset in the middle of LOCKED.
        drive_w(16'hA53C, 1'b1, 1'b0);
        expect_stat("pre_rst_lock", 25, 4'b1100);
        repeat (25) drive_w(16'hA53C, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        push("async_rst", 0, 1'b1, 1'b1, 16'h0000, 1'b1, 4'b0000);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        while (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL %0s: expectation never checked (due cycle %0d)", sb[0].name, sb[0].due);
            void'(sb.pop_front());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
